// File: rtl/spi_slave_param.sv
// rtl/spi_slave_param.sv - parametrised SPI slave front end with read sequencing and abort reporting
module spi_slave_param #(
  parameter int DATA_W     = 8,
  parameter int LSB_FIRST  = 0,
  parameter int TX_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  output logic              MISO,
  output logic              busy,
  output logic              frame_err
);

  localparam int FRAME_W = DATA_W + 2;
  localparam int CNT_W   = $clog2(FRAME_W);
  // A zero timeout still needs a one-bit counter so the port-free logic stays legal.
  localparam int WAIT_W  = (TX_TIMEOUT > 0) ? $clog2(TX_TIMEOUT + 1) : 1;

  localparam logic [CNT_W-1:0]  LAST_RX    = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0]  LAST_TX    = CNT_W'(DATA_W - 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TX_TIMEOUT);
  localparam logic [1:0]        CMD_RD_ADDR = 2'b10;
  localparam logic [1:0]        CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {IDLE, RX, WAIT_TX, TX, DONE} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    bit_cnt, bit_cnt_nxt;
  logic [WAIT_W-1:0]   wait_cnt, wait_cnt_nxt;
  logic [DATA_W:0]     shift_reg, shift_nxt;
  logic [DATA_W-1:0]   tx_shift, tx_shift_nxt;
  logic [DATA_W+1:0]   rx_data_nxt;
  logic                rx_valid_nxt, miso_nxt, frame_err_nxt;
  logic                rd_addr_ok, rd_addr_ok_nxt;

  logic [FRAME_W-1:0]  frame_word;
  logic [1:0]          frame_cmd;
  logic [DATA_W-1:0]   payload_raw, payload_nat;
  logic                tx_first_bit, tx_cur_bit;
  logic [DATA_W-1:0]   tx_load_shift, tx_adv_shift;
  logic [WAIT_W-1:0]   wait_inc;
  logic                wait_expired;

  // The frame as it would stand once the bit currently on MOSI is shifted in.
  assign frame_word  = {shift_reg, MOSI};
  assign frame_cmd   = frame_word[FRAME_W-1 -: 2];
  assign payload_raw = frame_word[DATA_W-1:0];

  // An LSB-first payload arrives reversed in the shift register; restore natural order.
  always_comb begin
    payload_nat = payload_raw;
    if (LSB_FIRST != 0) begin
      for (int i = 0; i < DATA_W; i++) begin
        payload_nat[i] = payload_raw[DATA_W-1-i];
      end
    end
  end

  // The tx shifter always presents the next bit at a fixed end, whichever order is selected.
  assign tx_first_bit  = (LSB_FIRST != 0) ? tx_data[0]  : tx_data[DATA_W-1];
  assign tx_load_shift = (LSB_FIRST != 0) ? (tx_data >> 1)  : (tx_data << 1);
  assign tx_cur_bit    = (LSB_FIRST != 0) ? tx_shift[0] : tx_shift[DATA_W-1];
  assign tx_adv_shift  = (LSB_FIRST != 0) ? (tx_shift >> 1) : (tx_shift << 1);

  assign wait_inc     = wait_cnt + WAIT_W'(1);
  assign wait_expired = (TX_TIMEOUT > 0) && (wait_inc == WAIT_LIMIT);

  assign busy = (state != IDLE);

  // Next-state and registered-output decode; counters clear unless the state is held.
  always_comb begin
    state_nxt      = state;
    bit_cnt_nxt    = '0;
    wait_cnt_nxt   = '0;
    shift_nxt      = shift_reg;
    tx_shift_nxt   = tx_shift;
    rx_data_nxt    = rx_data;
    rx_valid_nxt   = 1'b0;
    miso_nxt       = 1'b0;
    frame_err_nxt  = 1'b0;
    rd_addr_ok_nxt = rd_addr_ok;
    case (state)
      IDLE: begin
        if (!SS_n) begin
          shift_nxt   = frame_word[DATA_W:0];
          bit_cnt_nxt = CNT_W'(1);
          state_nxt   = RX;
        end
      end
      RX: begin
        if (SS_n) begin
          state_nxt     = IDLE;
          frame_err_nxt = 1'b1;
        end else begin
          shift_nxt   = frame_word[DATA_W:0];
          bit_cnt_nxt = bit_cnt + CNT_W'(1);
          if (bit_cnt == LAST_RX) begin
            bit_cnt_nxt  = '0;
            rx_data_nxt  = {frame_cmd, payload_nat};
            rx_valid_nxt = 1'b1;
            state_nxt    = DONE;
            if (frame_cmd == CMD_RD_ADDR) begin
              rd_addr_ok_nxt = 1'b1;
            end else if (frame_cmd == CMD_RD_DATA) begin
              rd_addr_ok_nxt = 1'b0;
              if (rd_addr_ok) begin
                state_nxt = WAIT_TX;
              end else begin
                frame_err_nxt = 1'b1;
              end
            end
          end
        end
      end
      WAIT_TX: begin
        if (SS_n) begin
          state_nxt     = IDLE;
          frame_err_nxt = 1'b1;
        end else if (tx_valid) begin
          tx_shift_nxt = tx_load_shift;
          miso_nxt     = tx_first_bit;
          state_nxt    = TX;
        end else if (wait_expired) begin
          frame_err_nxt = 1'b1;
          state_nxt     = DONE;
        end else begin
          wait_cnt_nxt = wait_inc;
        end
      end
      TX: begin
        if (SS_n) begin
          state_nxt     = IDLE;
          frame_err_nxt = 1'b1;
        end else if (bit_cnt == LAST_TX) begin
          state_nxt = DONE;
        end else begin
          miso_nxt     = tx_cur_bit;
          tx_shift_nxt = tx_adv_shift;
          bit_cnt_nxt  = bit_cnt + CNT_W'(1);
        end
      end
      DONE: begin
        if (SS_n) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers; reset wins over any frame in progress.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      wait_cnt   <= '0;
      shift_reg  <= '0;
      tx_shift   <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      MISO       <= 1'b0;
      frame_err  <= 1'b0;
      rd_addr_ok <= 1'b0;
    end else begin
      state      <= state_nxt;
      bit_cnt    <= bit_cnt_nxt;
      wait_cnt   <= wait_cnt_nxt;
      shift_reg  <= shift_nxt;
      tx_shift   <= tx_shift_nxt;
      rx_data    <= rx_data_nxt;
      rx_valid   <= rx_valid_nxt;
      MISO       <= miso_nxt;
      frame_err  <= frame_err_nxt;
      rd_addr_ok <= rd_addr_ok_nxt;
    end
  end

endmodule

// File: tb/tb_spi_slave_param.sv
// tb/tb_spi_slave_param.sv - directed scoreboard bench for spi_slave_param
module tb_spi_slave_param;

  logic        clk = 1'b0;
  logic        rst_n, SS_n, MOSI, tx_valid;
  logic [11:0] tx_data;

  logic [9:0]  rx_data_a;
  logic        rx_valid_a, miso_a, busy_a, frame_err_a;
  logic [13:0] rx_data_b;
  logic        rx_valid_b, miso_b, busy_b, frame_err_b;

  bit          sel;
  logic [13:0] obs_rx;
  logic        obs_rxv, obs_miso, obs_busy, obs_ferr;

  logic [13:0] rx_q[$];
  bit          miso_q[$];
  logic        exp_rxv, exp_ferr;
  logic [13:0] last_rx;
  bit          model_rd_ok;
  int          errors = 0;
  int          checks = 0;
  string       step;

  spi_slave_param #(.DATA_W(8), .LSB_FIRST(0), .TX_TIMEOUT(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI),
    .tx_valid(tx_valid), .tx_data(tx_data[7:0]),
    .rx_data(rx_data_a), .rx_valid(rx_valid_a), .MISO(miso_a),
    .busy(busy_a), .frame_err(frame_err_a)
  );

  spi_slave_param #(.DATA_W(12), .LSB_FIRST(1), .TX_TIMEOUT(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI),
    .tx_valid(tx_valid), .tx_data(tx_data),
    .rx_data(rx_data_b), .rx_valid(rx_valid_b), .MISO(miso_b),
    .busy(busy_b), .frame_err(frame_err_b)
  );

  always #5 clk = ~clk;

  // Observe whichever instance the current phase is exercising.
  always_comb begin
    obs_rx   = sel ? rx_data_b   : {4'b0000, rx_data_a};
    obs_rxv  = sel ? rx_valid_b  : rx_valid_a;
    obs_miso = sel ? miso_b      : miso_a;
    obs_busy = sel ? busy_b      : busy_a;
    obs_ferr = sel ? frame_err_b : frame_err_a;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s/%s observed=%0h expected=%0h", step, tag, obs, want);
    end
  endtask

  // Advance one cycle and compare the per-cycle outputs against the scoreboard.
  task automatic cyc();
    logic [13:0] want_rx;
    bit          want_miso;
    @(negedge clk);
    chk("rx_valid", obs_rxv, exp_rxv);
    if (obs_rxv && rx_q.size() > 0) begin
      want_rx = rx_q.pop_front();
      chk("rx_data", obs_rx, want_rx);
      last_rx = want_rx;
    end
    chk("frame_err", obs_ferr, exp_ferr);
    want_miso = (miso_q.size() > 0) ? miso_q.pop_front() : 1'b0;
    chk("miso", obs_miso, want_miso);
    exp_rxv  = 1'b0;
    exp_ferr = 1'b0;
  endtask

  task automatic send_frame(input logic [1:0] cmd, input logic [11:0] payload, input int dw, input bit lsb);
    for (int i = 0; i < dw + 2; i++) begin
      logic mosi_bit;
      if (i == 0)      mosi_bit = cmd[1];
      else if (i == 1) mosi_bit = cmd[0];
      else if (lsb)    mosi_bit = payload[i-2];
      else             mosi_bit = payload[dw-1-(i-2)];
      SS_n = 1'b0;
      MOSI = mosi_bit;
      if (i == dw + 1) begin
        rx_q.push_back((14'(cmd) << dw) | 14'(payload));
        exp_rxv = 1'b1;
        if (cmd == 2'b11) begin
          if (!model_rd_ok) exp_ferr = 1'b1;
          model_rd_ok = 1'b0;
        end else if (cmd == 2'b10) begin
          model_rd_ok = 1'b1;
        end
      end
      cyc();
      chk("busy_frame", obs_busy, 1);
    end
    MOSI = 1'b0;
  endtask

  task automatic end_frame();
    SS_n = 1'b1;
    MOSI = 1'b0;
    cyc();
    chk("busy_idle", obs_busy, 0);
  endtask

  task automatic push_tx(input logic [11:0] data, input int dw, input bit lsb);
    for (int i = 0; i < dw; i++) begin
      miso_q.push_back(lsb ? data[i] : data[dw-1-i]);
    end
  endtask

  initial begin
    rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = '0;
    sel = 1'b0; model_rd_ok = 1'b0; exp_rxv = 1'b0; exp_ferr = 1'b0; last_rx = '0;

    step = "reset";
    cyc(); cyc();
    rst_n = 1'b1;
    chk("rx_data_rst", obs_rx, 0);
    chk("busy_rst", obs_busy, 0);
    cyc();
    chk("busy_idle_ss_high", obs_busy, 0);

    step = "write_addr";
    send_frame(2'b00, 12'h0A5, 8, 0);
    end_frame();

    step = "read";
    send_frame(2'b10, 12'h03C, 8, 0);
    end_frame();
    send_frame(2'b11, 12'h000, 8, 0);
    cyc(); cyc();
    tx_valid = 1'b1; tx_data = 12'h0C3;
    push_tx(12'h0C3, 8, 0);
    cyc();
    tx_valid = 1'b0;
    repeat (8) begin
      cyc();
      chk("busy_tx", obs_busy, 1);
    end
    end_frame();

    step = "abort_rx";
    for (int i = 0; i < 5; i++) begin
      SS_n = 1'b0;
      MOSI = (i == 1 || i == 3);
      cyc();
      chk("busy_partial", obs_busy, 1);
    end
    SS_n = 1'b1; MOSI = 1'b0; exp_ferr = 1'b1;
    cyc();
    chk("busy_abort", obs_busy, 0);
    chk("rx_data_kept", obs_rx, last_rx);
    send_frame(2'b01, 12'h05A, 8, 0);
    end_frame();

    step = "abort_wait_tx";
    send_frame(2'b10, 12'h011, 8, 0);
    end_frame();
    send_frame(2'b11, 12'h000, 8, 0);
    SS_n = 1'b1; tx_valid = 1'b1; tx_data = 12'h0FF; exp_ferr = 1'b1;
    cyc();
    tx_valid = 1'b0;
    chk("busy_abort_wait", obs_busy, 0);

    step = "illegal_read";
    rst_n = 1'b0; SS_n = 1'b1;
    cyc();
    rst_n = 1'b1; model_rd_ok = 1'b0; last_rx = '0;
    chk("rx_data_rst2", obs_rx, 0);
    send_frame(2'b11, 12'h077, 8, 0);
    tx_valid = 1'b1; tx_data = 12'h0FF;
    cyc(); cyc();
    tx_valid = 1'b0;
    chk("busy_done", obs_busy, 1);
    end_frame();

    step = "timeout";
    send_frame(2'b10, 12'h042, 8, 0);
    end_frame();
    send_frame(2'b11, 12'h000, 8, 0);
    repeat (3) cyc();
    exp_ferr = 1'b1;
    cyc();
    tx_valid = 1'b1; tx_data = 12'h0AA;
    cyc(); cyc();
    tx_valid = 1'b0;
    chk("busy_after_timeout", obs_busy, 1);
    end_frame();

    step = "timeout_tie";
    send_frame(2'b10, 12'h043, 8, 0);
    end_frame();
    send_frame(2'b11, 12'h000, 8, 0);
    repeat (3) cyc();
    tx_valid = 1'b1; tx_data = 12'h096;
    push_tx(12'h096, 8, 0);
    cyc();
    tx_valid = 1'b0;
    repeat (8) cyc();
    end_frame();

    step = "abort_tx";
    send_frame(2'b10, 12'h044, 8, 0);
    end_frame();
    send_frame(2'b11, 12'h000, 8, 0);
    tx_valid = 1'b1; tx_data = 12'h0F0;
    push_tx(12'h0F0, 8, 0);
    cyc();
    tx_valid = 1'b0;
    cyc(); cyc();
    SS_n = 1'b1; exp_ferr = 1'b1;
    miso_q.delete();
    cyc();
    chk("busy_abort_tx", obs_busy, 0);

    step = "lsb_reset";
    sel = 1'b1;
    rst_n = 1'b0; SS_n = 1'b1;
    cyc();
    rst_n = 1'b1; model_rd_ok = 1'b0; last_rx = '0;
    chk("rx_data_rst_b", obs_rx, 0);
    chk("busy_rst_b", obs_busy, 0);

    step = "lsb_write";
    send_frame(2'b01, 12'hA5C, 12, 1);
    end_frame();

    step = "lsb_read";
    send_frame(2'b10, 12'h123, 12, 1);
    end_frame();
    send_frame(2'b11, 12'h000, 12, 1);
    tx_valid = 1'b1; tx_data = 12'h801;
    push_tx(12'h801, 12, 1);
    cyc();
    tx_valid = 1'b0;
    repeat (12) cyc();
    end_frame();

    step = "lsb_reset_mid_tx";
    send_frame(2'b10, 12'h456, 12, 1);
    end_frame();
    send_frame(2'b11, 12'h000, 12, 1);
    tx_valid = 1'b1; tx_data = 12'h5A3;
    push_tx(12'h5A3, 12, 1);
    cyc();
    tx_valid = 1'b0;
    repeat (4) cyc();
    rst_n = 1'b0;
    miso_q.delete();
    cyc();
    chk("busy_reset_tx", obs_busy, 0);
    chk("rx_data_reset_tx", obs_rx, 0);
    rst_n = 1'b1; SS_n = 1'b1;
    cyc();
    chk("busy_after_reset", obs_busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
